// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB widths and requester slot assignments
package cdb_arbiter_pkg;
  localparam int CDB_TAG_W = 8;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_NREQ = 4;
  localparam int CDB_CNT_W = 16;
  localparam int CDB_SLOT_ALU = 0;
  localparam int CDB_SLOT_MUL = 1;
  localparam int CDB_SLOT_LSU = 2;
  localparam int CDB_SLOT_BR = 3;
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, first set request at or after ptr
module rr_picker #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);
  // Scan farthest-to-nearest so the nearest requester at or after ptr wins.
  always_comb begin
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) gnt_idx = PW'((int'(ptr) + i) % N);
  end
  assign any = |req;
  assign gnt = any ? N'(1) << gnt_idx : '0;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter with registered broadcast, flush, tag-0 check and grant stats
import cdb_arbiter_pkg::*;
module cdb_arbiter #(
  parameter int N_REQ = CDB_NREQ,
  parameter int TAG_W = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W,
  parameter int CNT_W = CDB_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    br,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*TAG_W-1:0]  req_index,
  input  logic [N_REQ*DATA_W-1:0] req_result,
  output logic [N_REQ-1:0]        grnt,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_index,
  output logic [DATA_W-1:0]       cdb_result,
  output logic                    err_tag0,
  output logic [N_REQ*CNT_W-1:0]  grant_cnt
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0] rr_ptr, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic pick_any, xfer, tag0;
  logic [TAG_W-1:0] win_index;
  logic [CNT_W-1:0] cnt [N_REQ];
  rr_picker #(.N(N_REQ), .PW(PW)) u_pick (
    .req(req), .ptr(rr_ptr), .gnt(pick_gnt), .gnt_idx(pick_idx), .any(pick_any)
  );
  // Reset and flush both suppress the grant in the same cycle.
  assign xfer = pick_any & ~rst & ~br;
  assign grnt = xfer ? pick_gnt : '0;
  assign win_index = req_index[pick_idx*TAG_W +: TAG_W];
  assign tag0 = win_index == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_index <= '0;
      cdb_result <= '0;
      err_tag0 <= 1'b0;
    end else begin
      cdb_valid <= xfer & ~tag0;
      if (xfer & ~tag0) begin
        cdb_index <= win_index;
        cdb_result <= req_result[pick_idx*DATA_W +: DATA_W];
      end
      if (xfer) rr_ptr <= pick_idx == PW'(N_REQ - 1) ? '0 : pick_idx + PW'(1);
      err_tag0 <= err_tag0 | (xfer & tag0);
    end
  end
  for (genvar k = 0; k < N_REQ; k++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst) cnt[k] <= '0;
      else if (xfer && pick_gnt[k] && !(&cnt[k])) cnt[k] <= cnt[k] + CNT_W'(1);
    end
    assign grant_cnt[k*CNT_W +: CNT_W] = cnt[k];
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven vectors with a CDB scoreboard for cdb_arbiter
module tb_cdb_arbiter;
  localparam int N = 4, TW = 8, DW = 32, CW = 2;
  logic clk = 0, rst, br;
  logic [N-1:0] req, grnt;
  logic [N*TW-1:0] req_index;
  logic [N*DW-1:0] req_result;
  logic cdb_valid, err_tag0;
  logic [TW-1:0] cdb_index;
  logic [DW-1:0] cdb_result;
  logic [N*CW-1:0] grant_cnt;
  int checks = 0, failures = 0;
  typedef struct {logic rst; logic br; logic [3:0] req; logic [3:0] grnt; logic [7:0] tag; logic [31:0] res;} vec_t;
  typedef struct {logic v; logic [7:0] idx; logic [31:0] res;} exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  logic [7:0] last_i = 0;
  logic [31:0] last_r = 0;
  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .br(br), .req(req), .req_index(req_index), .req_result(req_result),
    .grnt(grnt), .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_result(cdb_result),
    .err_tag0(err_tag0), .grant_cnt(grant_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic b, input logic [3:0] rq, input logic [3:0] g);
    vecs.push_back('{r, b, rq, g, 8'h20 + 8'(vecs.size()), 32'hC0DE0000 + 32'(vecs.size())});
  endtask
  task automatic chk_cnt(input string name, input logic [CW-1:0] e0, input logic [CW-1:0] e1,
                         input logic [CW-1:0] e2, input logic [CW-1:0] e3);
    chk({name, "_cnt0"}, 32'(grant_cnt[0 +: CW]), 32'(e0));
    chk({name, "_cnt1"}, 32'(grant_cnt[CW +: CW]), 32'(e1));
    chk({name, "_cnt2"}, 32'(grant_cnt[2*CW +: CW]), 32'(e2));
    chk({name, "_cnt3"}, 32'(grant_cnt[3*CW +: CW]), 32'(e3));
  endtask
  // Winner (per the table's expected grant) carries the vector's tag/result; losers carry fixed values.
  task automatic run(input int i);
    vec_t v;
    exp_t e;
    v = vecs[i];
    rst = v.rst; br = v.br; req = v.req;
    for (int k = 0; k < N; k++) begin
      req_index[k*TW +: TW] = v.grnt[k] ? v.tag : (8'hE0 | 8'(k));
      req_result[k*DW +: DW] = v.grnt[k] ? v.res : (32'h0BAD0000 | 32'(k));
    end
    #1 chk($sformatf("grnt[%0d]", i), 32'(grnt), 32'(v.grnt));
    if (v.rst) begin
      last_i = 0; last_r = 0;
    end else if (v.grnt != 0 && v.tag != 0) begin
      last_i = v.tag; last_r = v.res;
    end
    sb.push_back('{!v.rst && v.grnt != 0 && v.tag != 0, last_i, last_r});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk($sformatf("cdb_valid[%0d]", i), 32'(cdb_valid), 32'(e.v));
    chk($sformatf("cdb_index[%0d]", i), 32'(cdb_index), 32'(e.idx));
    chk($sformatf("cdb_result[%0d]", i), cdb_result, e.res);
  endtask
  initial begin
    for (int i = 0; i < 8; i++) add(0, 0, 4'b1111, 4'b0001 << (i % 4));
    add(0, 0, 4'b0100, 4'b0100);
    add(0, 0, 4'b0000, 4'b0000);
    add(0, 0, 4'b1001, 4'b1000);
    add(0, 0, 4'b1001, 4'b0001);
    add(0, 0, 4'b0000, 4'b0000);
    add(0, 0, 4'b1111, 4'b0010);
    add(0, 1, 4'b0010, 4'b0000);
    add(0, 0, 4'b0010, 4'b0010);
    add(0, 0, 4'b0000, 4'b0000);
    add(0, 1, 4'b1111, 4'b0000);
    add(0, 0, 4'b1111, 4'b0100);
    add(1, 1, 4'b1111, 4'b0000);
    add(0, 0, 4'b1111, 4'b0001);
    add(0, 0, 4'b0010, 4'b0010);
    add(0, 0, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) add(0, 0, 4'b0001, 4'b0001);
    vecs[8].tag = 8'h15; vecs[8].res = 32'hDEADBEEF;
    vecs[21].tag = 8'h00;
    rst = 1; br = 0; req = '0; req_index = '0; req_result = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grnt", 32'(grnt), 0);
    chk("rst_valid", 32'(cdb_valid), 0);
    chk("rst_index", 32'(cdb_index), 0);
    chk("rst_result", cdb_result, 0);
    chk("rst_err", 32'(err_tag0), 0);
    chk_cnt("rst", 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) run(i);
    chk_cnt("rotate", 2, 2, 2, 2);
    for (int i = 8; i < 20; i++) run(i);
    chk_cnt("midrst", 0, 0, 0, 0);
    chk("midrst_err", 32'(err_tag0), 0);
    run(20);
    run(21);
    chk("tag0_err", 32'(err_tag0), 1);
    chk_cnt("tag0", 1, 1, 0, 0);
    for (int i = 22; i < 28; i++) run(i);
    chk_cnt("sat", 3, 1, 0, 0);
    chk("sticky_err", 32'(err_tag0), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
